// File: rtl/uart_cmd_pkg.sv
// Shared protocol constants and FSM state encoding for the UART command decoder.
package uart_cmd_pkg;

   localparam logic [7:0] SYNC      = 8'hA5;
   localparam logic [7:0] CMD_PING  = 8'h00;
   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR_HI = 3'd2,
      ST_ADDR_LO = 3'd3,
      ST_DATA    = 3'd4,
      ST_WRITE   = 3'd5,
      ST_RESP    = 3'd6,
      ST_TX_WAIT = 3'd7
   } state_t;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th idle cycle elapses.
module uart_cmd_timer #(
   parameter int TIMEOUT = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // Saturates at the terminal count so a stalled enable can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && cnt != TC)
         cnt <= cnt + CW'(1);
   end

   assign expired = enable && !clear && (cnt == TC);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes SYNC/CMD framed byte streams from a UART into ping responses and
// single-byte memory writes, answering each accepted frame with ACK or NAK.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | hunting for SYNC, other bytes dropped
// ST_CMD     | waiting for command byte
// ST_ADDR_HI | waiting for address high byte
// ST_ADDR_LO | waiting for address low byte
// ST_DATA    | waiting for write data byte
// ST_WRITE   | wr_en held until wr_ready
// ST_RESP    | response loaded, waiting for transmitter idle
// ST_TX_WAIT | response in flight, waiting for transmitter idle
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic              wr_ready,
   output logic              err
);

   state_t      state;
   logic        rx_prev;
   logic [7:0]  addr_hi_q;
   logic [7:0]  addr_lo_q;
   logic [15:0] addr_full;
   logic        byte_evt;
   logic        tmr_clear;
   logic        tmr_en;
   logic        tmr_expired;

   assign byte_evt  = rx_valid && !rx_prev;
   assign addr_full = {addr_hi_q, addr_lo_q};
   assign tmr_en    = (state == ST_CMD) || (state == ST_ADDR_HI) ||
                      (state == ST_ADDR_LO) || (state == ST_DATA);
   assign tmr_clear = byte_evt || (state == ST_IDLE);

   uart_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rx_prev   <= 1'b0;
         addr_hi_q <= '0;
         addr_lo_q <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         err       <= 1'b0;
      end else begin
         rx_prev  <= rx_valid;
         tx_start <= 1'b0;
         err      <= 1'b0;
         // Receive states test byte_evt first so a byte beats a same-cycle timeout.
         case (state)
            ST_IDLE: begin
               if (byte_evt && rx_data == SYNC)
                  state <= ST_CMD;
            end
            ST_CMD: begin
               if (byte_evt) begin
                  if (rx_data == CMD_PING) begin
                     tx_data <= ACK;
                     state   <= ST_RESP;
                  end else if (rx_data == CMD_WRITE) begin
                     state   <= ST_ADDR_HI;
                  end else begin
                     tx_data <= NAK;
                     err     <= 1'b1;
                     state   <= ST_RESP;
                  end
               end else if (tmr_expired) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            ST_ADDR_HI: begin
               if (byte_evt) begin
                  addr_hi_q <= rx_data;
                  state     <= ST_ADDR_LO;
               end else if (tmr_expired) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            ST_ADDR_LO: begin
               if (byte_evt) begin
                  addr_lo_q <= rx_data;
                  state     <= ST_DATA;
               end else if (tmr_expired) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (byte_evt) begin
                  wr_addr <= addr_full[ADDR_W-1:0];
                  wr_data <= rx_data;
                  wr_en   <= 1'b1;
                  state   <= ST_WRITE;
               end else if (tmr_expired) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               if (wr_ready) begin
                  wr_en   <= 1'b0;
                  tx_data <= ACK;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  state    <= ST_TX_WAIT;
               end
            end
            ST_TX_WAIT: begin
               // tx_busy only rises the cycle after tx_start, so skip that first cycle.
               if (!tx_start && !tx_busy)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
